// File: rtl/telemetry_pkg.sv
// Shared types and constants for the telemetry framer.
package telemetry_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SYNC0,
    ST_SYNC1,
    ST_SEQ,
    ST_LEN,
    ST_LATCH,
    ST_SEND,
    ST_CHK
  } state_t;

  localparam logic [7:0] SYNC0_DEF = 8'hA5;
  localparam logic [7:0] SYNC1_DEF = 8'h5A;

  // Payload length byte for an inclusive address window.
  function automatic logic [7:0] calc_len(input int first_addr, input int last_addr);
    return 8'(last_addr - first_addr + 1);
  endfunction

endpackage

// File: rtl/telemetry_framer_timer.sv
// Periodic trigger source: free-running counter that wraps every PERIOD_CYC cycles.
module frame_timer #(
  parameter int PERIOD_CYC = 100000,
  parameter int CNT_W      = 17
) (
  input  logic clk,
  input  logic rst,
  input  logic enable,
  output logic tick
);

  localparam logic [CNT_W-1:0] LAST = CNT_W'(PERIOD_CYC - 1);

  logic [CNT_W-1:0] cnt;

  // Tick is asserted during the cycle the counter sits on its terminal value.
  assign tick = enable && (cnt == LAST);

  // Count while enabled, wrap at the terminal value, clear whenever disabled.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                cnt <= '0;
    else if (!enable)       cnt <= '0;
    else if (cnt == LAST)   cnt <= '0;
    else                    cnt <= cnt + 1'b1;
  end

endmodule

// File: rtl/telemetry_framer.sv
// Reads a window of sensor registers on each trigger and streams it out as a
// framed packet: SYNC0 SYNC1 SEQ LEN payload CHK over a valid/ready byte port.
module telemetry_framer
  import telemetry_pkg::*;
#(
  parameter int         FIRST_ADDR = 1,
  parameter int         LAST_ADDR  = 25,
  parameter logic [7:0] SYNC0      = SYNC0_DEF,
  parameter logic [7:0] SYNC1      = SYNC1_DEF,
  parameter int         PERIOD_CYC = 100000,
  parameter int         CNT_W      = 17
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       enable,
  input  logic       start,
  output logic [7:0] sensor_addr,
  input  logic [7:0] sensor_data,
  output logic [7:0] tx_data,
  output logic       tx_valid,
  input  logic       tx_ready,
  output logic       busy,
  output logic [7:0] seq,
  output logic       overrun
);

  localparam logic [7:0] LEN    = calc_len(FIRST_ADDR, LAST_ADDR);
  localparam logic [7:0] FIRST_A = 8'(FIRST_ADDR);
  localparam logic [7:0] LAST_A  = 8'(LAST_ADDR);

  state_t     state_q, state_d;
  logic       tick;
  logic       trigger;
  logic       xfer;
  logic [7:0] acc;   // running sum of SEQ, LEN and payload bytes

  frame_timer #(
    .PERIOD_CYC(PERIOD_CYC),
    .CNT_W     (CNT_W)
  ) u_timer (
    .clk   (clk),
    .rst   (rst),
    .enable(enable),
    .tick  (tick)
  );

  assign trigger = start | tick;
  assign xfer    = tx_valid & tx_ready;

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  // Next-state: header bytes advance on transfer, payload alternates LATCH/SEND.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (trigger) state_d = ST_SYNC0;
      ST_SYNC0: if (xfer)    state_d = ST_SYNC1;
      ST_SYNC1: if (xfer)    state_d = ST_SEQ;
      ST_SEQ:   if (xfer)    state_d = ST_LEN;
      ST_LEN:   if (xfer)    state_d = ST_LATCH;
      ST_LATCH:              state_d = ST_SEND;
      ST_SEND:  if (xfer)    state_d = (sensor_addr == LAST_A) ? ST_CHK : ST_LATCH;
      ST_CHK:   if (xfer)    state_d = ST_IDLE;
      default:               state_d = ST_IDLE;
    endcase
  end

  // Datapath: output byte, handshake, address walk, checksum and sequence.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sensor_addr <= '0;
      tx_data     <= '0;
      tx_valid    <= 1'b0;
      busy        <= 1'b0;
      seq         <= '0;
      overrun     <= 1'b0;
      acc         <= '0;
    end else begin
      overrun <= trigger && (state_q != ST_IDLE);
      case (state_q)
        ST_IDLE: if (trigger) begin
          tx_data  <= SYNC0;
          tx_valid <= 1'b1;
          busy     <= 1'b1;
          acc      <= '0;
        end
        ST_SYNC0: if (xfer) tx_data <= SYNC1;
        ST_SYNC1: if (xfer) tx_data <= seq;
        ST_SEQ: if (xfer) begin
          tx_data <= LEN;
          acc     <= acc + seq;
        end
        ST_LEN: if (xfer) begin
          acc         <= acc + LEN;
          sensor_addr <= FIRST_A;
          tx_valid    <= 1'b0;
        end
        ST_LATCH: begin
          tx_data  <= sensor_data;
          acc      <= acc + sensor_data;
          tx_valid <= 1'b1;
        end
        ST_SEND: if (xfer) begin
          if (sensor_addr == LAST_A) begin
            // acc already holds every payload byte; negate so the frame sums to 0
            tx_data <= 8'd0 - acc;
          end else begin
            sensor_addr <= sensor_addr + 8'd1;
            tx_valid    <= 1'b0;
          end
        end
        ST_CHK: if (xfer) begin
          seq      <= seq + 8'd1;
          busy     <= 1'b0;
          tx_valid <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_telemetry_framer.sv
// Directed bench for telemetry_framer: frame contents, timing, backpressure,
// overrun, periodic triggering, sequence wrap and asynchronous reset.
module tb_telemetry_framer;

  localparam int NB = 30;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       enable = 1'b0;
  logic       start = 1'b0;
  logic [7:0] sensor_addr;
  logic [7:0] sensor_data;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready = 1'b1;
  logic       busy;
  logic [7:0] seq;
  logic       overrun;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int e0;

  logic [7:0] bank [0:255];
  logic [7:0] exp_b [0:NB-1];
  logic [7:0] exp_seq;
  logic [7:0] got [$];
  int         got_edge [$];
  int         stall_bad, busy_drop, ov_cnt;

  telemetry_framer #(.PERIOD_CYC(100), .CNT_W(7)) dut (
    .clk        (clk),
    .rst        (rst),
    .enable     (enable),
    .start      (start),
    .sensor_addr(sensor_addr),
    .sensor_data(sensor_data),
    .tx_data    (tx_data),
    .tx_valid   (tx_valid),
    .tx_ready   (tx_ready),
    .busy       (busy),
    .seq        (seq),
    .overrun    (overrun)
  );

  assign sensor_data = bank[sensor_addr];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #1000000;
    $display("FAIL watchdog: sim time limit reached, required finish earlier");
    $fatal(1, "watchdog");
  end

  // Expected frame for a given sequence number from the bank model.
  task automatic compute_exp(input logic [7:0] s);
    logic [7:0] sum;
    exp_b[0] = 8'hA5; exp_b[1] = 8'h5A; exp_b[2] = s; exp_b[3] = 8'd25;
    sum = s + 8'd25;
    for (int k = 0; k < 25; k++) begin
      exp_b[4+k] = bank[k+1];
      sum = sum + bank[k+1];
    end
    exp_b[29] = 8'd0 - sum;
  endtask

  task automatic pulse_start();
    @(posedge clk); #2 start = 1'b1;
    @(posedge clk); #1 e0 = cyc; start = 1'b0;
  endtask

  // Gathers transferred bytes (and their edge numbers) until a full frame or timeout.
  task automatic collect(input bit rnd, input int maxcyc);
    int stall; bit pstall; logic [7:0] pdata;
    got.delete(); got_edge.delete();
    stall_bad = 0; busy_drop = 0; ov_cnt = 0; stall = 0; pstall = 0; pdata = 0;
    for (int i = 0; i < maxcyc; i++) begin
      @(negedge clk);
      if (overrun) ov_cnt++;
      if (pstall && (tx_valid !== 1'b1 || tx_data !== pdata)) stall_bad++;
      if (got.size() > 0 && !busy) busy_drop++;
      if (rnd && stall < 10 && $urandom_range(0, 2) == 0) begin tx_ready = 1'b0; stall++; end
      else begin tx_ready = 1'b1; stall = 0; end
      pstall = tx_valid && !tx_ready;
      pdata  = tx_data;
      if (tx_valid && tx_ready) begin
        got.push_back(tx_data);
        got_edge.push_back(cyc + 1);
        if (got.size() == NB) begin @(posedge clk); #1; break; end
      end
    end
    tx_ready = 1'b1;
  endtask

  task automatic check_frame(input string name);
    checks++;
    if (got.size() != NB) begin
      errors++; $display("FAIL %s_len: got %0d bytes, required %0d", name, got.size(), NB);
    end
    for (int i = 0; i < NB; i++) begin
      checks++;
      if (got.size() <= i || got[i] !== exp_b[i]) begin
        errors++;
        $display("FAIL %s_byte%0d: got %h, required %h", name, i, (got.size() > i) ? got[i] : 8'hxx, exp_b[i]);
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #2;
    checks += 6;
    if (tx_valid !== 1'b0) begin errors++; $display("FAIL rst_tx_valid: got %b, required 0", tx_valid); end
    if (busy !== 1'b0)     begin errors++; $display("FAIL rst_busy: got %b, required 0", busy); end
    if (seq !== 8'h00)     begin errors++; $display("FAIL rst_seq: got %h, required 00", seq); end
    if (sensor_addr !== 8'h00) begin errors++; $display("FAIL rst_addr: got %h, required 00", sensor_addr); end
    if (tx_data !== 8'h00) begin errors++; $display("FAIL rst_tx_data: got %h, required 00", tx_data); end
    if (overrun !== 1'b0)  begin errors++; $display("FAIL rst_overrun: got %b, required 0", overrun); end
    rst = 1'b0;
    exp_seq = 8'h00;
  endtask

  task automatic test_basic();
    pulse_start();
    collect(1'b0, 100);
    compute_exp(exp_seq);
    check_frame("basic");
    checks += 7;
    if (got[29] !== 8'h4B) begin errors++; $display("FAIL basic_chk: got %h, required 4b", got[29]); end
    if (got_edge[0] !== e0 + 1) begin errors++; $display("FAIL basic_sync0_edge: got E%0d, required E%0d", got_edge[0] - e0, 1); end
    if (got_edge[3] !== e0 + 4) begin errors++; $display("FAIL basic_len_edge: got E%0d, required E4", got_edge[3] - e0); end
    if (got_edge[4] !== e0 + 6) begin errors++; $display("FAIL basic_pay1_edge: got E%0d, required E6", got_edge[4] - e0); end
    if (got_edge[29] !== e0 + 55) begin errors++; $display("FAIL basic_chk_edge: got E%0d, required E55", got_edge[29] - e0); end
    if (seq !== 8'h01) begin errors++; $display("FAIL basic_seq: got %h, required 01", seq); end
    if (busy !== 1'b0 || busy_drop != 0) begin errors++; $display("FAIL basic_busy: end %b drops %0d, required 0 0", busy, busy_drop); end
    exp_seq++;
  endtask

  task automatic test_backpressure();
    pulse_start();
    collect(1'b1, 1000);
    compute_exp(exp_seq);
    check_frame("bp");
    checks += 2;
    if (stall_bad != 0) begin errors++; $display("FAIL bp_stall_stable: %0d violations, required 0", stall_bad); end
    if (seq !== exp_seq + 8'd1) begin errors++; $display("FAIL bp_seq: got %h, required %h", seq, exp_seq + 8'd1); end
    exp_seq++;
  endtask

  task automatic test_overrun();
    pulse_start();
    fork
      collect(1'b0, 100);
      begin
        repeat (9) @(posedge clk);
        #2 start = 1'b1;
        @(posedge clk); #3 start = 1'b0;
        checks++;
        if (overrun !== 1'b1) begin errors++; $display("FAIL ovr_pulse: got %b, required 1", overrun); end
        @(posedge clk); #3;
        checks++;
        if (overrun !== 1'b0) begin errors++; $display("FAIL ovr_pulse_end: got %b, required 0", overrun); end
      end
    join
    compute_exp(exp_seq);
    check_frame("ovr");
    repeat (20) @(negedge clk);
    checks += 3;
    if (ov_cnt != 1) begin errors++; $display("FAIL ovr_count: got %0d, required 1", ov_cnt); end
    if (busy_drop != 0) begin errors++; $display("FAIL ovr_busy_drop: got %0d, required 0", busy_drop); end
    if (busy !== 1'b0 || tx_valid !== 1'b0) begin errors++; $display("FAIL ovr_single_frame: busy %b valid %b, required 0 0", busy, tx_valid); end
    exp_seq++;
  endtask

  task automatic test_periodic();
    int first [3];
    int ovs, act;
    ovs = 0;
    @(posedge clk); #2 enable = 1'b1;
    for (int f = 0; f < 3; f++) begin
      collect(1'b0, 250);
      ovs += ov_cnt;
      first[f] = (got_edge.size() > 0) ? got_edge[0] : -1000;
      compute_exp(exp_seq);
      check_frame("per");
      exp_seq++;
    end
    #2 enable = 1'b0;
    checks += 3;
    if (first[1] - first[0] != 100) begin errors++; $display("FAIL per_spacing1: got %0d, required 100", first[1] - first[0]); end
    if (first[2] - first[1] != 100) begin errors++; $display("FAIL per_spacing2: got %0d, required 100", first[2] - first[1]); end
    if (ovs != 0) begin errors++; $display("FAIL per_overrun: got %0d, required 0", ovs); end
    act = 0;
    repeat (300) begin @(negedge clk); if (tx_valid || busy) act++; end
    checks++;
    if (act != 0) begin errors++; $display("FAIL per_disable: %0d active cycles, required 0", act); end
  endtask

  task automatic test_seq_wrap();
    bit ok;
    rst = 1'b1; repeat (2) @(posedge clk); #2 rst = 1'b0;
    exp_seq = 8'h00;
    for (int f = 1; f <= 257; f++) begin
      pulse_start();
      collect(1'b0, 100);
      compute_exp(exp_seq);
      ok = (got.size() == NB);
      for (int i = 0; i < NB && ok; i++) if (got[i] !== exp_b[i]) ok = 0;
      checks++;
      if (!ok) begin errors++; $display("FAIL wrap_frame%0d: seq byte %h chk %h, required %h %h", f, (got.size() > 2) ? got[2] : 8'hxx, (got.size() == NB) ? got[29] : 8'hxx, exp_b[2], exp_b[29]); end
      if (f == 256) begin
        checks += 2;
        if (got[2] !== 8'hFF) begin errors++; $display("FAIL wrap_seq256: got %h, required ff", got[2]); end
        if (got[29] !== 8'h4C) begin errors++; $display("FAIL wrap_chk256: got %h, required 4c", got[29]); end
      end
      if (f == 257) begin
        checks += 2;
        if (got[2] !== 8'h00) begin errors++; $display("FAIL wrap_seq257: got %h, required 00", got[2]); end
        if (got[29] !== 8'h4B) begin errors++; $display("FAIL wrap_chk257: got %h, required 4b", got[29]); end
      end
      exp_seq++;
    end
  endtask

  task automatic test_reset_mid();
    bit found;
    found = 0;
    pulse_start();
    for (int i = 0; i < 100 && !found; i++) begin
      @(negedge clk);
      if (sensor_addr == 8'd7 && tx_valid) found = 1;
    end
    checks++;
    if (!found) begin errors++; $display("FAIL rmid_reach_byte7: not reached, required within 100 cycles"); end
    #2 rst = 1'b1;
    #1;
    checks += 4;
    if (tx_valid !== 1'b0) begin errors++; $display("FAIL rmid_tx_valid: got %b, required 0", tx_valid); end
    if (busy !== 1'b0)     begin errors++; $display("FAIL rmid_busy: got %b, required 0", busy); end
    if (sensor_addr !== 8'h00) begin errors++; $display("FAIL rmid_addr: got %h, required 00", sensor_addr); end
    if (seq !== 8'h00)     begin errors++; $display("FAIL rmid_seq: got %h, required 00", seq); end
    @(posedge clk); #2 rst = 1'b0;
    repeat (5) @(negedge clk);
    checks++;
    if (tx_valid !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL rmid_no_resume: valid %b busy %b, required 0 0", tx_valid, busy); end
    exp_seq = 8'h00;
    pulse_start();
    collect(1'b0, 100);
    compute_exp(exp_seq);
    check_frame("rmid");
  endtask

  initial begin
    for (int a = 0; a < 256; a++) bank[a] = 8'h00;
    bank[1] = 8'h12; bank[2] = 8'h34; bank[3] = 8'h56;
    exp_seq = 8'h00;
    test_reset();
    test_basic();
    test_backpressure();
    test_overrun();
    test_periodic();
    test_seq_wrap();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/telemetry_framer.md
Name: telemetry_framer

Overview:
- Downstream consumer of the sensor register bank's address/data byte port.
- On each trigger (external pulse or periodic tick) it walks sensor addresses FIRST_ADDR..LAST_ADDR, reading one byte per address.
- It wraps the payload in a framed packet: sync, sequence, length, payload, checksum.
- It streams the packet byte-by-byte over a valid/ready interface to the UART/radio transmitter.

Parameters:
- FIRST_ADDR, 1, first sensor register address read.
- LAST_ADDR, 25, last sensor register address read (inclusive; must be ≥ FIRST_ADDR).
- SYNC0, 8'hA5, first sync byte.
- SYNC1, 8'h5A, second sync byte.
- PERIOD_CYC, 100000, clk cycles between periodic triggers when enable=1 (≥ 2).
- CNT_W, 17, period counter width; must satisfy 2^CNT_W ≥ PERIOD_CYC.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  reset, asynchronous, active-high.
- enable  in  1  enables periodic trigger counter.
- start  in  1  single-cycle manual frame trigger.
- sensor_addr  out  8  address to sensor register bank.
- sensor_data  in  8  byte returned by bank for sensor_addr (combinational in addr).
- tx_data  out  8  packet byte.
- tx_valid  out  1  tx_data valid.
- tx_ready  in  1  sink accepts byte.
- busy  out  1  frame in progress.
- seq  out  8  sequence number of the next/current frame.
- overrun  out  1  one-cycle pulse: trigger arrived while busy.

Behaviour:
- Reset values: sensor_addr=0, tx_data=0, tx_valid=0, busy=0, seq=0, overrun=0, period counter=0, state=IDLE.
- Reset mid-frame aborts immediately (async): tx_valid drops; no partial continuation after release.
- Packet format, in order: SYNC0, SYNC1, SEQ, LEN, payload[FIRST_ADDR..LAST_ADDR], CHK.
  - LEN = LAST_ADDR-FIRST_ADDR+1, which is 25 by default.
  - CHK = (256 - (SEQ+LEN+Σpayload) mod 256) mod 256, so the 8-bit sum of SEQ..CHK is 0.
- Period counter: counts while enable=1, clears while enable=0. At PERIOD_CYC-1 it wraps to 0 and emits a one-cycle tick.
- trigger = start | tick.
- Trigger in IDLE:
  - At the next edge: state=SYNC0, tx_data=SYNC0, tx_valid=1, busy=1.
  - The checksum accumulator clears.
- Trigger while busy: dropped; overrun=1 for one cycle. A trigger in the same cycle the CHK byte transfers is also an overrun.
- Handshake:
  - A byte transfers on a rising edge with tx_valid&tx_ready.
  - While tx_valid=1 and tx_ready=0, tx_data is held stable and tx_valid stays high.
  - tx_valid is never withdrawn except by reset.
- State machine:
  - IDLE→SYNC0→SYNC1→SEQ→LEN→(LATCH→SEND)×LEN→CHK→IDLE.
  - Header states advance on each transfer.
  - SEQ and LEN bytes are added to the checksum.
- Payload:
  - On LEN transfer: sensor_addr<=FIRST_ADDR, go LATCH (tx_valid=0).
  - LATCH (1 cycle): tx_data<=sensor_data, accumulate into checksum, tx_valid<=1, go SEND.
  - SEND on transfer: if sensor_addr==LAST_ADDR go CHK with tx_data=CHK; else sensor_addr<=sensor_addr+1 and go LATCH.
  - sensor_addr holds its last value after the frame.
- CHK transfer: seq<=seq+1 (wraps 255→0), busy=0, tx_valid=0, state IDLE.
- Timing with tx_ready held high, trigger sampled at edge E0:
  - SYNC0 transfers at E1, LEN at E4.
  - Payload byte k (1-based) transfers at E4+2k.
  - CHK transfers at E55.
  - busy is high E0..E55.
- Sensor values may update between payload bytes; cross-byte tearing of multi-byte fields is accepted at this stage.

Decomposition:
- Shared package telemetry_pkg holds:
  - state enum (IDLE, SYNC0, SYNC1, SEQ, LEN, LATCH, SEND, CHK);
  - default SYNC0/SYNC1 constants;
  - function computing LEN from FIRST/LAST.
- One sub-module: frame_timer (period counter plus tick; params PERIOD_CYC, CNT_W; ports clk, rst, enable, tick).

Test Plan:
- Basic frame, tx_ready=1, model bank with pressure=0x123456 (addr1..3 = 12,34,56), all other addresses 0, start pulse.
  - Required: 30 bytes A5 5A 00 19 12 34 56 00×22 4B.
  - CHK=0x4B; last transfer at E55; seq becomes 1.
- Backpressure: same frame, tx_ready toggles randomly (≤10-cycle stalls).
  - Required: identical byte sequence.
  - tx_data stable and tx_valid high throughout every stall; no duplicates or drops.
- Overrun: start pulses at E0 and E10.
  - Required: overrun=1 exactly one cycle after E10; a single frame only; busy never drops early.
- Periodic trigger: PERIOD_CYC=100, enable=1, tx_ready=1.
  - Required: frames start every 100 cycles; seq counts 0,1,2…; overrun stays 0.
  - Deasserting enable stops new frames.
- Sequence wrap: run 257 frames.
  - Required: frame 256 carries SEQ=0xFF, frame 257 carries SEQ=0x00, and each CHK is correct for its SEQ.
- Reset mid-frame: assert rst asynchronously during payload byte 7.
  - Required: tx_valid, busy and sensor_addr go to 0 immediately, seq=0.
  - The next start produces a complete, correct frame beginning with A5.
